// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, unit ratios and FSM state encoding.
package morse_pkg;

  localparam logic [1:0] CODE_INACT = 2'b00;
  localparam logic [1:0] CODE_DOT   = 2'b01;
  localparam logic [1:0] CODE_DASH0 = 2'b10;
  localparam logic [1:0] CODE_DASH1 = 2'b11;

  localparam int DOT_UNITS   = 1;
  localparam int DASH_UNITS  = 3;
  localparam int SPACE_UNITS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Both upper codes are dashes, matching the decode side.
  function automatic logic is_dash(input logic [1:0] code);
    return (code == CODE_DASH0) || (code == CODE_DASH1);
  endfunction

  function automatic logic is_inact(input logic [1:0] code);
    return code == CODE_INACT;
  endfunction

endpackage

// File: rtl/morse_symbol_transmitter_if.sv
// Symbol handshake between an upstream sequencer and the transmitter.
interface morse_symbol_transmitter_if;
  logic [1:0] code_in;
  logic       code_valid;
  logic       code_ready;

  modport master (output code_in, output code_valid, input code_ready);
  modport slave  (input code_in, input code_valid, output code_ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Loadable down-counter; expire flags the last cycle of the loaded interval.
module morse_unit_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count  = r_count;
  assign expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/morse_symbol_transmitter.sv
// Turns 2-bit Morse symbol codes into a timed key waveform (mark, space, gap).
module morse_symbol_transmitter
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 10000000,
  parameter int GAP_UNITS   = 2,
  parameter int CNT_W       = $clog2(3*UNIT_CYCLES+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  morse_symbol_transmitter_if.slave   sym_if,
  output logic                        key_out,
  output logic                        busy,
  output logic                        sym_done
);

  localparam logic [CNT_W-1:0] L_DOT   = CNT_W'(DOT_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] L_DASH  = CNT_W'(DASH_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] L_SPACE = CNT_W'(SPACE_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(GAP_UNITS * UNIT_CYCLES);

  state_t           r_state;
  state_t           w_next;
  logic             r_dash;
  logic             r_key;
  logic             r_busy;
  logic             r_sym_done;
  logic             w_accept;
  logic             w_dash_next;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_count;
  logic             w_expire;
  logic             w_sym_done;

  assign sym_if.code_ready = (r_state == IDLE) && en;
  assign w_accept          = sym_if.code_valid && sym_if.code_ready;

  // The mark length comes from the live code on acceptance, else from the latch.
  assign w_dash_next = (r_state == IDLE) ? is_dash(sym_if.code_in) : r_dash;

  morse_unit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_value (w_load_val),
    .count      (w_count),
    .expire     (w_expire)
  );

  // Next-state and timer load; every state change reloads the counter
  // (IDLE loads zero, which also clears it on an abort).
  always_comb begin
    w_next     = r_state;
    w_load_val = '0;
    if (!en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = is_inact(sym_if.code_in) ? GAP : MARK;
        MARK:    if (w_expire) w_next = SPACE;
        SPACE:   if (w_expire) w_next = IDLE;
        GAP:     if (w_expire) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
    case (w_next)
      MARK:    w_load_val = w_dash_next ? L_DASH : L_DOT;
      SPACE:   w_load_val = L_SPACE;
      GAP:     w_load_val = L_GAP;
      default: w_load_val = '0;
    endcase
    w_load     = (w_next != r_state);
    // Count of 2 now means the next cycle is the final one of the symbol.
    w_sym_done = en && ((r_state == SPACE) || (r_state == GAP)) &&
                 (w_count == CNT_W'(2));
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dash     <= 1'b0;
      r_key      <= 1'b0;
      r_busy     <= 1'b0;
      r_sym_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_key      <= (w_next == MARK);
      r_busy     <= (w_next != IDLE);
      r_sym_done <= w_sym_done;
      if (w_accept) r_dash <= is_dash(sym_if.code_in);
    end
  end

  assign key_out  = r_key;
  assign busy     = r_busy;
  assign sym_done = r_sym_done;

endmodule

// File: tb/tb_morse_symbol_transmitter.sv
// Randomized bench for morse_symbol_transmitter with a scoreboard of symbols.
module tb_morse_symbol_transmitter;

  localparam int U    = 4;
  localparam int GAPU = 2;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic key_out;
  logic busy;
  logic sym_done;

  morse_symbol_transmitter_if sym_if();

  morse_symbol_transmitter #(.UNIT_CYCLES(U), .GAP_UNITS(GAPU)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sym_if   (sym_if),
    .key_out  (key_out),
    .busy     (busy),
    .sym_done (sym_done)
  );

  always #5 clk = ~clk;

  // One accepted symbol: acceptance cycle, key-on length, total length.
  typedef struct {
    int acc;
    int mark;
    int total;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Morse timing rules: dot 1 unit on, dash 3 units on, then 1 unit off;
  // inactivity is GAPU silent units.
  function automatic exp_t model(input int acc, input logic [1:0] code);
    exp_t e;
    e.acc = acc;
    if (code == 2'b00) begin
      e.mark  = 0;
      e.total = GAPU * U;
    end else if (code == 2'b01) begin
      e.mark  = U;
      e.total = 2 * U;
    end else begin
      e.mark  = 3 * U;
      e.total = 4 * U;
    end
    return e;
  endfunction

  // Monitor: compare outputs each cycle against the head of the scoreboard.
  always @(negedge clk) begin
    bit exp_busy, exp_key, exp_done, exp_ready;
    int d;
    if (rst) begin
      check(key_out == 1'b0, "reset_key", int'(key_out), 0);
      check(busy == 1'b0, "reset_busy", int'(busy), 0);
      check(sym_done == 1'b0, "reset_done", int'(sym_done), 0);
      q.delete();
    end else begin
      exp_busy = (q.size() != 0);
      exp_key  = 1'b0;
      exp_done = 1'b0;
      d        = 0;
      if (exp_busy) begin
        d        = cyc - q[0].acc;
        exp_key  = (d >= 1) && (d <= q[0].mark);
        exp_done = (d == q[0].total);
      end
      exp_ready = en && !exp_busy;
      check(key_out == exp_key, "key_out", int'(key_out), int'(exp_key));
      check(busy == exp_busy, "busy", int'(busy), int'(exp_busy));
      check(sym_if.code_ready == exp_ready, "code_ready",
            int'(sym_if.code_ready), int'(exp_ready));
      if (sym_done) begin
        check(exp_done, "sym_done_timing", d, exp_busy ? q[0].total : -1);
        if (exp_busy) void'(q.pop_front());
      end else if (exp_done) begin
        check(1'b0, "sym_done_missing", 0, 1);
        void'(q.pop_front());
      end else if (exp_busy && !en) begin
        void'(q.pop_front());
      end
      if (exp_ready && sym_if.code_valid) q.push_back(model(cyc, sym_if.code_in));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a code and hold it until the block takes it.
  task automatic send(input logic [1:0] c);
    int n;
    sym_if.code_in    = c;
    sym_if.code_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (sym_if.code_ready) break;
      n++;
      if (n > 200) begin
        check(1'b0, "accept_timeout", n, 200);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0] c;
    int mode;
    int k;
    rst               = 1'b1;
    en                = 1'b0;
    sym_if.code_in    = 2'b00;
    sym_if.code_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) tick();

    // Dot, then two dashes back-to-back with valid held, then inactivity.
    send(2'b01);
    sym_if.code_valid = 1'b0;
    repeat (10) tick();
    send(2'b10);
    send(2'b11);
    sym_if.code_valid = 1'b0;
    repeat (20) tick();
    send(2'b00);
    sym_if.code_valid = 1'b0;
    repeat (12) tick();

    // Drop en in the second cycle of a dash.
    send(2'b10);
    sym_if.code_valid = 1'b0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check(sym_if.code_ready == 1'b0, "abort_ready", int'(sym_if.code_ready), 0);
      check(sym_done == 1'b0, "abort_no_done", int'(sym_done), 0);
    end
    en = 1'b1;
    tick();

    // A different code pulsed during a mark must be ignored.
    send(2'b01);
    sym_if.code_valid = 1'b0;
    tick();
    sym_if.code_in    = 2'b10;
    sym_if.code_valid = 1'b1;
    tick();
    sym_if.code_valid = 1'b0;
    repeat (10) tick();

    // Asynchronous reset in the middle of a dash mark.
    send(2'b10);
    sym_if.code_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check(key_out == 1'b0, "async_rst_key", int'(key_out), 0);
    check(busy == 1'b0, "async_rst_busy", int'(busy), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Random traffic: back-to-back, gaps, ignored pulses and aborts.
    for (int i = 0; i < 80; i++) begin
      c = 2'($urandom_range(0, 3));
      send(c);
      mode = $urandom_range(0, 3);
      case (mode)
        2: begin
          sym_if.code_valid = 1'b0;
          k = $urandom_range(0, 6);
          repeat (k) tick();
          sym_if.code_in    = c ^ 2'b01;
          sym_if.code_valid = 1'b1;
          tick();
          sym_if.code_valid = 1'b0;
          k = $urandom_range(0, 20);
          repeat (k) tick();
        end
        3: begin
          sym_if.code_valid = 1'b0;
          k = $urandom_range(0, 14);
          repeat (k) tick();
          en = 1'b0;
          k = $urandom_range(1, 3);
          repeat (k) tick();
          en = 1'b1;
        end
        default: ;
      endcase
    end
    sym_if.code_valid = 1'b0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_symbol_transmitter.md
Name: morse_symbol_transmitter

Overview:
- Opposite direction of the dot/dash decode path: takes the same 2-bit Morse symbol code and produces a timed on/off key waveform for an LED or buzzer.
- Symbols arrive from an upstream sequencer (e.g. a character-to-symbol ROM walker) over a valid/ready handshake.
- Output timing follows standard Morse unit ratios: dot = 1 unit mark, dash = 3 units, 1-unit inter-element space, inactivity = extended silent gap.

Parameters:
- UNIT_CYCLES, 10000000, clock cycles per Morse time unit (100 ms at 100 MHz); must be >= 2.
- GAP_UNITS, 2, silent units emitted for an inactivity code. Together with the trailing 1-unit space of the previous symbol, this gives a 3-unit letter gap.
- CNT_W, clog2(3*UNIT_CYCLES+1), width of the cycle counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low forces idle.
- code_in  in  2  symbol code: 00 inactivity, 01 dot, 10 dash, 11 dash.
- code_valid  in  1  code_in is valid this cycle.
- code_ready  out  1  block can accept a symbol; combinational, equals (state==IDLE) && en.
- key_out  out  1  registered key; 1 = tone/LED on.
- busy  out  1  registered; 1 whenever state != IDLE.
- sym_done  out  1  registered one-cycle pulse on the last cycle of a symbol.

Behaviour:
- Reset, asynchronous: state=IDLE, counter=0, key_out=0, busy=0, sym_done=0. A symbol in progress is discarded and key_out drops immediately.
- Handshake: a symbol is accepted on a rising edge where code_valid && code_ready. There is no input buffering; code_in is latched at acceptance.
- States:
  - IDLE: on accept, go to MARK (dot/dash) or GAP (inactivity).
  - MARK: key_out=1 for 1*UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash), then go to SPACE.
  - SPACE: key_out=0 for UNIT_CYCLES, then go to IDLE.
  - GAP: key_out=0 for GAP_UNITS*UNIT_CYCLES, then go to IDLE.
- Timing: if acceptance is sampled in cycle T, the new state and key_out take effect in cycle T+1.
  - MARK lasts exactly N*UNIT_CYCLES cycles.
  - sym_done=1 during the final cycle of SPACE or GAP.
  - The state is IDLE and code_ready is high (if en) in the cycle after sym_done.
- Counter: loaded at each state entry and decremented each cycle; the state exits when the count reaches 1. No wrap-around is possible.
- Back-to-back operation: with code_valid held high, the next symbol is accepted in the first IDLE cycle. Throughput is one symbol per (duration + 1 cycle).
- en deasserted mid-symbol: abort. Next cycle: state=IDLE, key_out=0, busy=0, no sym_done.
- en low in IDLE: code_ready=0 and nothing is accepted.
- code_valid while busy: ignored, because code_ready=0. The upstream block must hold its data.
- Codes 10 and 11 are both dash, consistent with the decode side.

Decomposition:
- Shared package morse_pkg:
  - Code constants: CODE_INACT=2'b00, CODE_DOT=2'b01, CODE_DASH0=2'b10, CODE_DASH1=2'b11.
  - Unit ratios: DOT_UNITS=1, DASH_UNITS=3, SPACE_UNITS=1.
  - State encoding: IDLE, MARK, SPACE, GAP.
- One sub-module, morse_unit_timer: a loadable down-counter with load, load_value and expire outputs. The FSM instantiates it once.

Test Plan (UNIT_CYCLES=4, GAP_UNITS=2):
- Reset behaviour: assert rst mid-MARK of a dash -> key_out=0 and busy=0 asynchronously. After release, code_ready=1 with en=1.
- Dot accepted in cycle T -> key_out=1 in T+1..T+4, 0 in T+5..T+8. sym_done=1 only in T+8. code_ready=1 in T+9.
- Dash (code 10, then code 11 back-to-back, valid held) -> first dash has key_out=1 in T+1..T+12 and sym_done in T+16. The second dash is accepted in T+17, with key_out=1 in T+18..T+29.
- Inactivity accepted in T -> key_out=0 throughout, busy=1 in T+1..T+8, sym_done in T+8.
- en dropped in T+2 of a dash -> key_out=0 and state IDLE from T+3, no sym_done pulse. code_ready stays 0 until en returns.
- code_valid pulsed during MARK with a different code -> not accepted, and the in-progress waveform is unchanged.
